// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the unified memory-port arbiter.
//   state_e : transaction sequencer states (IDLE arbitrate, ACC request, RSP wait)
//   owner_e : owner of the in-flight transaction, also the steering-mux select
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RSP  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/mem_port_arbiter_mux.sv
// Parameterised 2:1 mux.
//   sel : 0 selects in0, 1 selects in1
//   in0 : first operand  (Imlength bits)
//   in1 : second operand (Imlength bits)
//   out : selected operand
module mem_port_arbiter_mux #(
  parameter int Imlength = 32
) (
  input  logic                sel,
  input  logic [Imlength-1:0] in0,
  input  logic [Imlength-1:0] in1,
  output logic [Imlength-1:0] out
);

  assign out = sel ? in1 : in0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single memory port between instruction fetch (IF) and the data
// stage (D). Arbitrates in IDLE, captures the winner's request into the mem_*
// registers, holds mem_req until the memory accepts, then waits for the
// response and routes it back to the owner with a one-cycle rvalid pulse.
// Ports:
//   clk, rst_n                     : clock, asynchronous active-low reset
//   if_req/if_addr                 : fetch request in
//   if_gnt/if_rvalid/if_rdata      : fetch grant pulse, response pulse, data
//   d_req/d_we/d_addr/d_wdata/d_be : data request in (load or store)
//   d_gnt/d_rvalid/d_rdata         : data grant pulse, completion pulse, data
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be : captured request to memory
//   mem_ready/mem_rvalid/mem_rdata : memory accept, completion, read data
//   owner_sel                      : registered owner (0 = IF, 1 = D)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ready,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                owner_sel
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [3:0] MAX_STREAK = 4'(MAX_D_STREAK);

  state_e              state_reg, state_next;
  owner_e              owner_reg;
  logic [3:0]          d_streak_reg;
  logic                grant_if, grant_d;
  logic [ADDR_W-1:0]   addr_sel;
  logic [ADDR_W-1:0]   addr_reg;
  logic                we_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [BE_W-1:0]     be_reg;
  logic [DATA_W-1:0]   if_rdata_reg, d_rdata_reg;
  logic                if_rvalid_reg, d_rvalid_reg;

  // Arbitration and next state. D wins contention until it has taken
  // MAX_D_STREAK contested grants in a row, then IF is forced through.
  always_comb begin
    grant_if   = 1'b0;
    grant_d    = 1'b0;
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (d_req && (!if_req || d_streak_reg != MAX_STREAK)) begin
          grant_d = 1'b1;
        end else if (if_req) begin
          grant_if = 1'b1;
        end
        if (grant_if || grant_d) begin
          state_next = ACC;
        end
      end
      ACC: begin
        if (mem_ready) begin
          state_next = RSP;
        end
      end
      RSP: begin
        if (mem_rvalid) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Address steering into the capture register follows the winner.
  mem_port_arbiter_mux #(
    .Imlength(ADDR_W)
  ) u_addr_mux (
    .sel(grant_d),
    .in0(if_addr),
    .in1(d_addr),
    .out(addr_sel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      owner_reg     <= OWN_IF;
      d_streak_reg  <= '0;
      addr_reg      <= '0;
      we_reg        <= 1'b0;
      wdata_reg     <= '0;
      be_reg        <= '0;
      if_rdata_reg  <= '0;
      d_rdata_reg   <= '0;
      if_rvalid_reg <= 1'b0;
      d_rvalid_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      if_rvalid_reg <= 1'b0;
      d_rvalid_reg  <= 1'b0;

      if (grant_if || grant_d) begin
        owner_reg <= grant_d ? OWN_D : OWN_IF;
        addr_reg  <= addr_sel;
        we_reg    <= grant_d & d_we;
        // Only stores use the requester's byte enables; every read is full width.
        be_reg    <= (grant_d && d_we) ? d_be : '1;
        if (grant_d) begin
          wdata_reg <= d_wdata;
        end
      end

      if (grant_if) begin
        d_streak_reg <= '0;
      end else if (grant_d && if_req && d_streak_reg < MAX_STREAK) begin
        d_streak_reg <= d_streak_reg + 4'd1;
      end

      // Response is accepted only in RSP; stray mem_rvalid elsewhere is dropped.
      if (state_reg == RSP && mem_rvalid) begin
        if (owner_reg == OWN_D) begin
          d_rdata_reg  <= mem_rdata;
          d_rvalid_reg <= 1'b1;
        end else begin
          if_rdata_reg  <= mem_rdata;
          if_rvalid_reg <= 1'b1;
        end
      end
    end
  end

  assign if_gnt    = grant_if;
  assign d_gnt     = grant_d;
  assign if_rvalid = if_rvalid_reg;
  assign d_rvalid  = d_rvalid_reg;
  assign if_rdata  = if_rdata_reg;
  assign d_rdata   = d_rdata_reg;
  assign mem_req   = (state_reg == ACC);
  assign mem_we    = we_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign mem_be    = be_reg;
  assign owner_sel = owner_reg;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified memory port between instruction fetch (IF) and data access (D, load/store stage) in the pipelined RISC-V core.
- Arbitrates requests and captures the winner's address and data.
- Sequences a single outstanding memory transaction and routes the response back to the owner.
- Drives the owner-select used by the memory-side address/data steering mux.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be a multiple of 8.
- MAX_D_STREAK, 4, consecutive contested data grants allowed before IF is forced a grant; range 1..15.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  one-cycle grant pulse to IF.
- if_rvalid  out  1  one-cycle fetch response pulse.
- if_rdata  out  DATA_W  fetched instruction.
- d_req  in  1  data request.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_be  in  DATA_W/8  store byte enables.
- d_gnt  out  1  one-cycle grant pulse to D.
- d_rvalid  out  1  one-cycle completion pulse to D (loads and stores).
- d_rdata  out  DATA_W  load data.
- mem_req  out  1  request to memory.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_W  captured address.
- mem_wdata  out  DATA_W  captured write data.
- mem_be  out  DATA_W/8  captured byte enables; all ones on reads.
- mem_ready  in  1  memory accepts request this cycle.
- mem_rvalid  in  1  memory completes transaction (read data or write ack).
- mem_rdata  in  DATA_W  read data.
- owner_sel  out  1  registered owner, 0 = IF, 1 = D.

Behaviour:
- Single clock (clk).
- Reset (rst_n low, asynchronous, active-low) sets all outputs and state to 0: state = IDLE, owner_sel = 0, d_streak = 0, rdata registers = 0.
- States:
  - IDLE: arbitrate.
  - ACC: mem_req held high until mem_ready.
  - RSP: waiting for mem_rvalid.
- IDLE arbitration, one grant per cycle at most:
  - Only if_req: grant IF.
  - Only d_req: grant D.
  - Both: grant D unless d_streak == MAX_D_STREAK, then grant IF.
  - Neither: stay in IDLE, no outputs change.
- d_streak:
  - Increments, saturating, on a D grant while if_req is high.
  - Clears on any IF grant.
  - Unchanged on an uncontested D grant.
- Grant cycle (cycle 0):
  - The chosen gnt pulses for one cycle.
  - Address, we, wdata and be are captured into mem_* registers.
  - owner_sel updates.
  - Next state is ACC.
  - An IF capture forces we = 0 and be = all ones.
- After grant the requester may drop or change its req/addr; the captured values are held until completion.
- ACC: mem_req = 1 and mem_* are stable. When mem_ready is sampled high, next state is RSP and mem_req drops the following cycle.
- RSP: when mem_rvalid is sampled high:
  - Register mem_rdata into the owner's rdata.
  - Pulse the owner's rvalid one cycle later.
  - Next state is IDLE.
  - The other requester's rdata holds its previous value.
- Minimum latency: grant at cycle 0, mem_req at cycle 1, mem_ready at cycle 1, mem_rvalid at cycle 2, rvalid at cycle 3. The next grant is possible at cycle 3 (in IDLE).
- Boundary conditions:
  - mem_ready outside ACC: ignored.
  - mem_rvalid outside RSP: ignored, no rvalid pulse.
  - mem_ready and mem_rvalid high in the same ACC cycle: mem_rvalid ignored. One transaction is outstanding, so the response must come in a later cycle.
  - A request dropped before grant is never granted.
  - if_gnt and d_gnt are mutually exclusive. if_rvalid and d_rvalid are mutually exclusive.
  - Reset mid-transaction drops the transaction. No rvalid is produced, and the memory shares rst_n.
- No address alignment or width checking.

Decomposition:
- Package mem_arb_pkg:
  - state_e {IDLE, ACC, RSP}.
  - owner_e {OWN_IF = 1'b0, OWN_D = 1'b1}.
  - Default width constants ADDR_W_DEF = 32, DATA_W_DEF = 32.
- Sub-module: the team's parameterised 2:1 Mux (Imlength = ADDR_W) selects if_addr vs d_addr into the capture register, driven by the arbitration winner.
- All else is flat.

Test Plan:
- Single IF read: if_req = 1, if_addr = 0x100; memory has mem_ready at cycle 1 and mem_rvalid at cycle 2 with 0x00A00093. Required: if_gnt at cycle 0, mem_addr = 0x100 with mem_we = 0, if_rvalid at cycle 3 with if_rdata = 0x00A00093, d_rvalid never high.
- Store: d_req = 1, d_we = 1, d_addr = 0x2004, d_wdata = 0xDEADBEEF, d_be = 4'b0011; mem_ready delayed 3 cycles. Required: mem_req held with stable mem_* for 4 cycles, mem_be = 0011, d_rvalid one cycle after mem_rvalid.
- Contention with MAX_D_STREAK = 4: if_req and d_req held high continuously. Required grant order D,D,D,D,IF,D,D,D,D,IF.
- Spurious memory signals: pulse mem_rvalid in IDLE and mem_ready in RSP. Required: no rvalid pulse, no state change.
- Reset mid-transaction: assert rst_n = 0 during RSP, then release. Required: all outputs 0 immediately, no rvalid afterwards, a fresh if_req is granted from IDLE.
